// File: rtl/alarm_clock_multi.sv
// 24-hour clock with NUM_ALARMS programmable alarms, ring/snooze/timeout control
// and six 7-segment digits in 24-hour or 12-hour display mode.
module alarm_clock_multi #(
    parameter int CLK_DIV    = 1,
    parameter int NUM_ALARMS = 4,
    parameter int SNOOZE_MIN = 5,
    parameter int RING_SECS  = 60,
    parameter int AW         = (NUM_ALARMS > 2) ? $clog2(NUM_ALARMS) : 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          time_c,
    input  logic          alm_c,
    input  logic [5:0]    sec,
    input  logic [5:0]    min,
    input  logic [5:0]    hour,
    input  logic [AW-1:0] alm_sel,
    input  logic          alm_on,
    input  logic          alm_off,
    input  logic          snooze,
    input  logic          mode12,
    output logic [6:0]    outsc_1,
    output logic [6:0]    outsc_2,
    output logic [6:0]    outmn_1,
    output logic [6:0]    outmn_2,
    output logic [6:0]    outhr_1,
    output logic [6:0]    outhr_2,
    output logic          pm,
    output logic          alarm,
    output logic [AW-1:0] alarm_id,
    output logic          tick
);
    localparam int PW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    typedef enum logic [1:0] {S_IDLE = 2'd0, S_RING = 2'd1, S_SNOOZE = 2'd2} state_t;

    function automatic logic [6:0] seg7(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = 7'h3F;
            4'd1:    s = 7'h06;
            4'd2:    s = 7'h5B;
            4'd3:    s = 7'h4F;
            4'd4:    s = 7'h66;
            4'd5:    s = 7'h6D;
            4'd6:    s = 7'h7D;
            4'd7:    s = 7'h07;
            4'd8:    s = 7'h7F;
            4'd9:    s = 7'h6F;
            default: s = 7'h00;
        endcase
        return s;
    endfunction

    function automatic logic [3:0] tens(input logic [5:0] v);
        return 4'(v / 6'd10);
    endfunction

    function automatic logic [3:0] units(input logic [5:0] v);
        return 4'(v % 6'd10);
    endfunction

    logic [PW-1:0] presc_q, presc_d;
    logic [5:0]    sec_q, sec_d, min_q, min_d, hour_q, hour_d;
    logic          tick_q, tick_d;
    logic [5:0]    alm_h_q [NUM_ALARMS];
    logic [5:0]    alm_h_d [NUM_ALARMS];
    logic [5:0]    alm_m_q [NUM_ALARMS];
    logic [5:0]    alm_m_d [NUM_ALARMS];
    logic [NUM_ALARMS-1:0] en_q, en_d;
    state_t        state_q, state_d;
    logic [7:0]    ring_cnt_q, ring_cnt_d;
    logic [5:0]    tgt_h_q, tgt_h_d, tgt_m_q, tgt_m_d;
    logic [AW-1:0] id_q, id_d;
    logic          alarm_q, alarm_d;

    logic          tick_s, load_s, tick_ev_s, sel_ok_s, off_hit_s;
    logic          match_s;
    logic [AW-1:0] match_id_s;
    logic [6:0]    snz_sum_s;
    logic [5:0]    snz_h_s, snz_m_s, hour_disp_s;

    // A rejected time load is fully ignored, so the clock keeps running through it.
    assign tick_s    = (presc_q == PW'(CLK_DIV - 1));
    assign load_s    = time_c && (sec < 6'd60) && (min < 6'd60) && (hour < 6'd24);
    assign tick_ev_s = tick_s && !load_s;
    assign sel_ok_s  = (int'(alm_sel) < NUM_ALARMS);
    assign off_hit_s = alm_off && sel_ok_s && (alm_sel == id_q);
    assign snz_sum_s = {1'b0, min_q} + 7'(SNOOZE_MIN);

    // Prescaler and time-of-day next state.
    always_comb begin
        presc_d = presc_q;
        sec_d   = sec_q;
        min_d   = min_q;
        hour_d  = hour_q;
        tick_d  = 1'b0;
        if (load_s) begin
            presc_d = '0;
            sec_d   = sec;
            min_d   = min;
            hour_d  = hour;
        end else if (tick_s) begin
            presc_d = '0;
            tick_d  = 1'b1;
            if (sec_q == 6'd59) begin
                sec_d = 6'd0;
                if (min_q == 6'd59) begin
                    min_d  = 6'd0;
                    hour_d = (hour_q == 6'd23) ? 6'd0 : hour_q + 6'd1;
                end else begin
                    min_d = min_q + 6'd1;
                end
            end else begin
                sec_d = sec_q + 6'd1;
            end
        end else begin
            presc_d = presc_q + PW'(1);
        end
    end

    // Alarm slot contents and enables; disable beats enable.
    always_comb begin
        alm_h_d = alm_h_q;
        alm_m_d = alm_m_q;
        en_d    = en_q;
        if (alm_c && sel_ok_s && (hour < 6'd24) && (min < 6'd60)) begin
            alm_h_d[alm_sel] = hour;
            alm_m_d[alm_sel] = min;
        end else begin
            alm_h_d = alm_h_q;
        end
        if (sel_ok_s && alm_off) begin
            en_d[alm_sel] = 1'b0;
        end else if (sel_ok_s && alm_on) begin
            en_d[alm_sel] = 1'b1;
        end else begin
            en_d = en_q;
        end
    end

    // Lowest-index enabled slot equal to the time a tick is about to reach.
    always_comb begin
        match_s    = 1'b0;
        match_id_s = '0;
        for (int i = NUM_ALARMS - 1; i >= 0; i--) begin
            if (en_q[i] && (alm_h_q[i] == hour_d) && (alm_m_q[i] == min_d)) begin
                match_s    = 1'b1;
                match_id_s = AW'(i);
            end else begin
                match_s = match_s;
            end
        end
        match_s = match_s && tick_ev_s && (sec_d == 6'd0);
    end

    // Snooze target: current hh:mm plus SNOOZE_MIN with hour carry and wrap.
    always_comb begin
        snz_m_s = snz_sum_s[5:0];
        snz_h_s = hour_q;
        if (snz_sum_s >= 7'd60) begin
            snz_m_s = 6'(snz_sum_s - 7'd60);
            snz_h_s = (hour_q == 6'd23) ? 6'd0 : hour_q + 6'd1;
        end else begin
            snz_m_s = snz_sum_s[5:0];
        end
    end

    // Ring/snooze FSM next state; alarm output follows the next state.
    always_comb begin
        state_d    = state_q;
        ring_cnt_d = ring_cnt_q;
        tgt_h_d    = tgt_h_q;
        tgt_m_d    = tgt_m_q;
        id_d       = id_q;
        case (state_q)
            S_IDLE: begin
                if (match_s) begin
                    state_d    = S_RING;
                    id_d       = match_id_s;
                    ring_cnt_d = 8'd0;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_RING: begin
                if (load_s || off_hit_s) begin
                    state_d = S_IDLE;
                end else if (snooze) begin
                    state_d = S_SNOOZE;
                    tgt_h_d = snz_h_s;
                    tgt_m_d = snz_m_s;
                end else if (tick_ev_s) begin
                    ring_cnt_d = ring_cnt_q + 8'd1;
                    state_d    = (ring_cnt_q + 8'd1 >= 8'(RING_SECS)) ? S_IDLE : S_RING;
                end else begin
                    state_d = S_RING;
                end
            end
            S_SNOOZE: begin
                if (load_s || off_hit_s) begin
                    state_d = S_IDLE;
                end else if (tick_ev_s && (sec_d == 6'd0) && (hour_d == tgt_h_q) && (min_d == tgt_m_q)) begin
                    state_d    = S_RING;
                    ring_cnt_d = 8'd0;
                end else begin
                    state_d = S_SNOOZE;
                end
            end
            default: state_d = S_IDLE;
        endcase
        alarm_d = (state_d == S_RING);
    end

    // State registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            presc_q    <= '0;
            sec_q      <= 6'd0;
            min_q      <= 6'd0;
            hour_q     <= 6'd0;
            tick_q     <= 1'b0;
            alm_h_q    <= '{default: 6'd0};
            alm_m_q    <= '{default: 6'd0};
            en_q       <= '0;
            state_q    <= S_IDLE;
            ring_cnt_q <= 8'd0;
            tgt_h_q    <= 6'd0;
            tgt_m_q    <= 6'd0;
            id_q       <= '0;
            alarm_q    <= 1'b0;
        end else begin
            presc_q    <= presc_d;
            sec_q      <= sec_d;
            min_q      <= min_d;
            hour_q     <= hour_d;
            tick_q     <= tick_d;
            alm_h_q    <= alm_h_d;
            alm_m_q    <= alm_m_d;
            en_q       <= en_d;
            state_q    <= state_d;
            ring_cnt_q <= ring_cnt_d;
            tgt_h_q    <= tgt_h_d;
            tgt_m_q    <= tgt_m_d;
            id_q       <= id_d;
            alarm_q    <= alarm_d;
        end
    end

    // Displayed hour: 0 reads 12 and 13..23 fold down in 12-hour mode.
    always_comb begin
        hour_disp_s = hour_q;
        if (mode12) begin
            if (hour_q == 6'd0) begin
                hour_disp_s = 6'd12;
            end else if (hour_q > 6'd12) begin
                hour_disp_s = hour_q - 6'd12;
            end else begin
                hour_disp_s = hour_q;
            end
        end else begin
            hour_disp_s = hour_q;
        end
    end

    assign outsc_1  = seg7(tens(sec_q));
    assign outsc_2  = seg7(units(sec_q));
    assign outmn_1  = seg7(tens(min_q));
    assign outmn_2  = seg7(units(min_q));
    assign outhr_1  = seg7(tens(hour_disp_s));
    assign outhr_2  = seg7(units(hour_disp_s));
    assign pm       = (hour_q >= 6'd12);
    assign alarm    = alarm_q;
    assign alarm_id = id_q;
    assign tick     = tick_q;
endmodule

// File: tb/tb_alarm_clock_multi.sv
// Self-checking bench for alarm_clock_multi: display vector table fed through a
// scoreboard queue, plus sequences for rollover, reset, ring, snooze and timeout.
module tb_alarm_clock_multi;
    localparam int AW = 2;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          time_c = 1'b0, alm_c = 1'b0, alm_on = 1'b0, alm_off = 1'b0;
    logic          snooze = 1'b0, mode12 = 1'b0;
    logic [5:0]    sec = 6'd0, min = 6'd0, hour = 6'd0;
    logic [AW-1:0] alm_sel = '0;
    logic [6:0]    outsc_1, outsc_2, outmn_1, outmn_2, outhr_1, outhr_2;
    logic          pm, alarm, tick;
    logic [AW-1:0] alarm_id;

    int n_pass  = 0;
    int n_total = 0;

    typedef struct {
        logic [5:0]  h, m, s;
        logic        m12;
        logic [13:0] e_hr, e_mn, e_sc;
        logic        e_pm;
    } vec_t;

    typedef struct {
        logic [13:0] hr, mn, sc;
        logic        pm;
    } exp_t;

    vec_t vt [8];
    exp_t sbq [$];

    alarm_clock_multi #(
        .CLK_DIV(1), .NUM_ALARMS(4), .SNOOZE_MIN(5), .RING_SECS(60)
    ) dut (
        .clk(clk), .rst(rst), .time_c(time_c), .alm_c(alm_c),
        .sec(sec), .min(min), .hour(hour), .alm_sel(alm_sel),
        .alm_on(alm_on), .alm_off(alm_off), .snooze(snooze), .mode12(mode12),
        .outsc_1(outsc_1), .outsc_2(outsc_2), .outmn_1(outmn_1), .outmn_2(outmn_2),
        .outhr_1(outhr_1), .outhr_2(outhr_2), .pm(pm), .alarm(alarm),
        .alarm_id(alarm_id), .tick(tick)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    function automatic logic [6:0] seg(input int d);
        case (d)
            0: return 7'h3F;  1: return 7'h06;  2: return 7'h5B;  3: return 7'h4F;
            4: return 7'h66;  5: return 7'h6D;  6: return 7'h7D;  7: return 7'h07;
            8: return 7'h7F;  9: return 7'h6F;
            default: return 7'h00;
        endcase
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_time(input string nm, input int h, input int m, input int s);
        int hd;
        hd = mode12 ? ((h == 0) ? 12 : ((h > 12) ? h - 12 : h)) : h;
        chk({nm, " hr"}, {outhr_1, outhr_2}, {seg(hd / 10), seg(hd % 10)});
        chk({nm, " mn"}, {outmn_1, outmn_2}, {seg(m / 10), seg(m % 10)});
        chk({nm, " sc"}, {outsc_1, outsc_2}, {seg(s / 10), seg(s % 10)});
        chk({nm, " pm"}, pm, (h >= 12));
    endtask

    task automatic load_time(input int h, input int m, input int s);
        time_c = 1'b1; hour = 6'(h); min = 6'(m); sec = 6'(s);
        step();
        time_c = 1'b0;
    endtask

    task automatic prog_alarm(input int slot, input int h, input int m);
        alm_c = 1'b1; alm_on = 1'b1; alm_sel = AW'(slot); hour = 6'(h); min = 6'(m);
        step();
        alm_c = 1'b0; alm_on = 1'b0;
    endtask

    task automatic disable_slot(input int slot);
        alm_off = 1'b1; alm_sel = AW'(slot);
        step();
        alm_off = 1'b0;
    endtask

    task automatic wait_alarm(input string nm, input logic v, input int maxc, output int n);
        n = 0;
        while (alarm !== v && n < maxc) begin
            step();
            n++;
        end
        chk({nm, " wait"}, alarm, v);
    endtask

    initial begin
        exp_t e;
        int   n;

        vt[0] = '{h:6'd23, m:6'd59, s:6'd58, m12:1'b0, e_hr:{7'h5B,7'h4F}, e_mn:{7'h6D,7'h6F}, e_sc:{7'h6D,7'h7F}, e_pm:1'b1};
        vt[1] = '{h:6'd13, m:6'd5,  s:6'd0,  m12:1'b1, e_hr:{7'h3F,7'h06}, e_mn:{7'h3F,7'h6D}, e_sc:{7'h3F,7'h3F}, e_pm:1'b1};
        vt[2] = '{h:6'd0,  m:6'd30, s:6'd0,  m12:1'b1, e_hr:{7'h06,7'h5B}, e_mn:{7'h4F,7'h3F}, e_sc:{7'h3F,7'h3F}, e_pm:1'b0};
        vt[3] = '{h:6'd12, m:6'd0,  s:6'd7,  m12:1'b1, e_hr:{7'h06,7'h5B}, e_mn:{7'h3F,7'h3F}, e_sc:{7'h3F,7'h07}, e_pm:1'b1};
        vt[4] = '{h:6'd11, m:6'd45, s:6'd30, m12:1'b1, e_hr:{7'h06,7'h06}, e_mn:{7'h66,7'h6D}, e_sc:{7'h4F,7'h3F}, e_pm:1'b0};
        vt[5] = '{h:6'd0,  m:6'd0,  s:6'd0,  m12:1'b0, e_hr:{7'h3F,7'h3F}, e_mn:{7'h3F,7'h3F}, e_sc:{7'h3F,7'h3F}, e_pm:1'b0};
        vt[6] = '{h:6'd19, m:6'd27, s:6'd41, m12:1'b0, e_hr:{7'h06,7'h6F}, e_mn:{7'h5B,7'h07}, e_sc:{7'h66,7'h06}, e_pm:1'b1};
        vt[7] = '{h:6'd23, m:6'd0,  s:6'd0,  m12:1'b1, e_hr:{7'h06,7'h06}, e_mn:{7'h3F,7'h3F}, e_sc:{7'h3F,7'h3F}, e_pm:1'b1};

        // Power-on reset state
        #12;
        chk("rst segs", {outhr_1, outhr_2, outmn_1, outmn_2, outsc_1, outsc_2}, {6{7'h3F}});
        chk("rst alarm", alarm, 1'b0);
        chk("rst id", alarm_id, 2'd0);
        chk("rst tick", tick, 1'b0);
        chk("rst pm", pm, 1'b0);
        mode12 = 1'b1;
        #1;
        chk("rst hr12", {outhr_1, outhr_2}, {7'h06, 7'h5B});
        mode12 = 1'b0;
        rst = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            chk($sformatf("tick c%0d", i), tick, 1'b1);
        end
        check_time("run5", 0, 0, 5);

        // Asynchronous reset in the middle of a running count
        load_time(12, 34, 56);
        step();
        #3;
        rst = 1'b0;
        #1;
        chk("midrst segs", {outhr_1, outhr_2, outmn_1, outmn_2, outsc_1, outsc_2}, {6{7'h3F}});
        chk("midrst tick", tick, 1'b0);
        chk("midrst alarm", alarm, 1'b0);
        rst = 1'b1;
        step();
        chk("post tick", tick, 1'b1);
        check_time("post", 0, 0, 1);

        // Display vector table through the scoreboard
        for (int i = 0; i < 8; i++) begin
            time_c = 1'b1; hour = vt[i].h; min = vt[i].m; sec = vt[i].s; mode12 = vt[i].m12;
            sbq.push_back('{hr: vt[i].e_hr, mn: vt[i].e_mn, sc: vt[i].e_sc, pm: vt[i].e_pm});
            step();
            time_c = 1'b0;
            e = sbq.pop_front();
            chk($sformatf("vec%0d hr", i), {outhr_1, outhr_2}, e.hr);
            chk($sformatf("vec%0d mn", i), {outmn_1, outmn_2}, e.mn);
            chk($sformatf("vec%0d sc", i), {outsc_1, outsc_2}, e.sc);
            chk($sformatf("vec%0d pm", i), pm, e.pm);
        end
        mode12 = 1'b0;

        // Midnight rollover and rejected loads
        load_time(23, 59, 58);
        step();
        step();
        check_time("wrap", 0, 0, 0);
        load_time(24, 0, 0);
        check_time("bad hour", 0, 0, 1);
        load_time(0, 0, 60);
        check_time("bad sec", 0, 0, 2);

        // Slot 2 ring, snooze, re-ring, stop
        prog_alarm(2, 0, 1);
        load_time(0, 0, 58);
        chk("pre alarm", alarm, 1'b0);
        wait_alarm("ring2", 1'b1, 5, n);
        chk("ring2 lat", 64'(n), 64'd2);
        check_time("ring2", 0, 1, 0);
        chk("ring2 id", alarm_id, 2'd2);
        snooze = 1'b1;
        step();
        snooze = 1'b0;
        chk("snooze off", alarm, 1'b0);
        wait_alarm("resnz", 1'b1, 400, n);
        chk("resnz lat", 64'(n), 64'd299);
        check_time("resnz", 0, 6, 0);
        chk("resnz id", alarm_id, 2'd2);
        disable_slot(2);
        chk("stop2", alarm, 1'b0);
        load_time(0, 0, 58);
        for (int i = 0; i < 4; i++) begin
            step();
            chk($sformatf("slot2 off c%0d", i), alarm, 1'b0);
        end

        // Two slots match: lowest wins, ring times out
        prog_alarm(1, 0, 1);
        prog_alarm(3, 0, 1);
        load_time(0, 0, 58);
        wait_alarm("ring1", 1'b1, 5, n);
        chk("ring1 lat", 64'(n), 64'd2);
        chk("ring1 id", alarm_id, 2'd1);
        check_time("ring1", 0, 1, 0);
        wait_alarm("timeout", 1'b0, 100, n);
        chk("timeout len", 64'(n), 64'd60);
        check_time("timeout", 0, 2, 0);

        // Rejected alarm write keeps old 00:00; time load cancels ringing
        disable_slot(1);
        disable_slot(3);
        prog_alarm(0, 24, 1);
        load_time(23, 59, 58);
        wait_alarm("ring0", 1'b1, 5, n);
        chk("ring0 lat", 64'(n), 64'd2);
        chk("ring0 id", alarm_id, 2'd0);
        check_time("ring0", 0, 0, 0);
        load_time(10, 0, 0);
        chk("load cancel", alarm, 1'b0);
        check_time("load cancel", 10, 0, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: run exceeded time limit, %0d/%0d passed", n_pass, n_total);
        $fatal(1);
    end
endmodule

// File: doc/alarm_clock_multi.md
Name: alarm_clock_multi

Overview:
Parametrised successor to the single-alarm digital clock. It keeps a 24-hour time-of-day counter driven by a programmable prescaler and holds NUM_ALARMS independently programmable alarms. A ring/snooze/timeout state machine runs the alarm output, and the block drives six 7-segment digits in 24-hour or 12-hour display mode. It sits between the board clock and the display/buzzer pins.

Parameters:
CLK_DIV, 1, clk cycles per one-second tick (1 = tick every cycle, used for simulation)
NUM_ALARMS, 4, number of alarm slots (2..16)
SNOOZE_MIN, 5, snooze length in minutes (1..59)
RING_SECS, 60, automatic ring timeout in seconds (1..255)

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous active-low reset
time_c  in  1  load time from sec/min/hour
alm_c  in  1  write hour/min into alarm slot alm_sel
sec  in  6  time-load seconds
min  in  6  time-load or alarm minutes
hour  in  6  time-load or alarm hours
alm_sel  in  AW  alarm slot index; AW = max(1, clog2(NUM_ALARMS))
alm_on  in  1  enable slot alm_sel
alm_off  in  1  disable slot alm_sel; also stops that slot if it is ringing or snoozed
snooze  in  1  snooze request
mode12  in  1  1 = 12-hour display
outsc_1, outsc_2, outmn_1, outmn_2, outhr_1, outhr_2  out  7 each  segments gfedcba, active-high; _1 = tens digit, _2 = units digit
pm  out  1  high when hour >= 12, in both display modes
alarm  out  1  ringing
alarm_id  out  AW  index of the slot that is ringing or snoozed
tick  out  1  one-cycle pulse, once per second

Behaviour:
- Reset (rst=0, asynchronous):
  - time 00:00:00, prescaler 0
  - all alarm slots 00:00 and disabled
  - FSM IDLE; alarm=0, alarm_id=0, tick=0
  - displays show 00:00:00 (0x3F per digit) in 24-hour mode; in 12-hour mode the hour digits show "12"; pm=0
- Prescaler:
  - counts 0..CLK_DIV-1
  - tick=1 in the cycle where count==CLK_DIV-1, then the counter wraps to 0
- Time counter (updates on the tick cycle):
  - sec 59 -> 0 and carries into min
  - min 59 -> 0 and carries into hour
  - hour 23 -> 0
- time_c:
  - Takes priority over tick.
  - Loads sec/min/hour on the clock edge and clears the prescaler.
  - If sec>59, min>59 or hour>23, the load is rejected and time is unchanged.
  - A valid load while the FSM is in RING or SNOOZE forces IDLE, alarm=0.
- alm_c:
  - Writes hour/min to slot alm_sel; sec is ignored.
  - Invalid values are rejected.
  - alm_sel >= NUM_ALARMS is ignored.
- Enable controls:
  - alm_on sets enable[alm_sel]; alm_off clears it.
  - If both are asserted in the same cycle, alm_off wins.
- Match condition: an enabled slot where the time reached on a tick is hh:mm:00 and equals the slot's hh:mm.
  - If several slots match, the lowest index wins.
  - A match from a slot loaded by time_c does not ring; only tick-reached times ring.
- FSM (registered outputs; alarm rises the cycle after the matching tick):
  - IDLE:
    - match -> RING; alarm_id = winning slot; ring counter = 0
  - RING, alarm=1:
    - ring counter increments per tick; reaching RING_SECS -> IDLE
    - snooze=1 -> SNOOZE; target = current hh:mm + SNOOZE_MIN, carrying min -> hour, hour wraps 23 -> 0
    - alm_off with alm_sel==alarm_id -> IDLE, and that slot is disabled
    - New matches from other slots are ignored.
    - snooze and alm_off in the same cycle: alm_off wins.
  - SNOOZE, alarm=0:
    - tick reaching target hh:mm:00 -> RING; ring counter = 0
    - alm_off on alarm_id -> IDLE
    - Matches from other slots are ignored.
- Display (combinational from registers):
  - 24-hour mode: plain decimal digits.
  - 12-hour mode: hour 0 shows 12; hours 1-12 show as-is; hours 13-23 show hour-12.
- Segment codes 0..9: 3F 06 5B 4F 66 6D 7D 07 7F 6F.

Test Plan:
1. Reset asserted mid-count (CLK_DIV=1) -> immediately all six digits = 0x3F, alarm=0, alarm_id=0; after release, tick pulses every cycle.
2. time_c with 23:59:58, then 2 ticks -> time 00:00:00, pm=0; a load of 24:00:00 is ignored and time keeps counting.
3. Slot 2 programmed 00:01 and enabled; time loaded 00:00:58 -> tick to 00:01:00, alarm=1 on the next cycle, alarm_id=2.
4. While ringing, pulse snooze (SNOOZE_MIN=5) -> alarm=0 next cycle; rings again at 00:06:00 with alarm_id=2; then alm_off with alm_sel=2 -> alarm=0 and slot 2 disabled.
5. Slots 1 and 3 both at 00:01 -> alarm_id=1; with no action, alarm drops after RING_SECS=60 ticks, at 00:02:00.
6. mode12=1 with time 13:05:00 -> outhr_1=0x3F, outhr_2=0x06, pm=1; time 00:30:00 -> outhr = 0x06, 0x5B ("12"), pm=0.
